// File: rtl/fifo_burst_arb_if.sv
// Bundles the FIFO write port and both requester ports of fifo_burst_arb.
// The master modport is the arbiter side and the slave modport is the environment side.
interface fifo_burst_arb_if;
  logic        fifo_rdy;
  logic        fifo_full;
  logic [7:0]  fifo_dcnt;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        s0_valid;
  logic        s1_valid;
  logic [31:0] s0_data;
  logic [31:0] s1_data;
  logic        s0_ready;
  logic        s1_ready;
  logic        owner;
  logic        busy;
  logic [15:0] burst_cnt;

  modport master (
    input  fifo_rdy, fifo_full, fifo_dcnt, s0_valid, s1_valid, s0_data, s1_data,
    output fifo_wr_en, fifo_din, s0_ready, s1_ready, owner, busy, burst_cnt
  );

  modport slave (
    output fifo_rdy, fifo_full, fifo_dcnt, s0_valid, s1_valid, s0_data, s1_data,
    input  fifo_wr_en, fifo_din, s0_ready, s1_ready, owner, busy, burst_cnt
  );
endinterface

// File: rtl/fifo_burst_arb.sv
// Two-requester round-robin arbiter that writes fixed-length bursts into a FIFO.
// Define FIFO_BURST_ARB_HDR_EN to precede each burst with a one-word 0xA5 header.
module fifo_burst_arb #(
  parameter int DEPTH     = 256,
  parameter int BURST_LEN = 16
) (
  input logic               clk,
  input logic               rst,
  fifo_burst_arb_if.master  bus
);

`ifdef FIFO_BURST_ARB_HDR_EN
  localparam int THRESH = BURST_LEN + 1;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`else
  localparam int THRESH = BURST_LEN;
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t      state;
  logic        owner_q;
  logic        prio;
  logic [6:0]  word_cnt;
  logic [15:0] burst_cnt_q;

  logic [8:0]  free;
  logic        grant_ok;
  logic        grant_sel;
  logic        owner_valid;
  logic        accept;
  logic        last_word;

  assign free        = bus.fifo_full ? 9'd0 : 9'(DEPTH) - {1'b0, bus.fifo_dcnt};
  assign grant_ok    = bus.fifo_rdy && (bus.s0_valid || bus.s1_valid) && (free >= 9'(THRESH));
  // When both requesters are valid the one holding priority wins; otherwise the lone valid one.
  assign grant_sel   = (bus.s0_valid && bus.s1_valid) ? prio : bus.s1_valid;
  assign owner_valid = owner_q ? bus.s1_valid : bus.s0_valid;
  assign accept      = (state == DATA) && owner_valid && !bus.fifo_full && !rst;
  assign last_word   = (word_cnt == 7'(BURST_LEN - 1));

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_q     <= 1'b0;
      prio        <= 1'b0;
      word_cnt    <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            owner_q <= grant_sel;
`ifdef FIFO_BURST_ARB_HDR_EN
            state   <= HDR;
`else
            state   <= DATA;
`endif
          end
        end
`ifdef FIFO_BURST_ARB_HDR_EN
        HDR: state <= DATA;
`endif
        DATA: begin
          if (accept) begin
            if (last_word) begin
              word_cnt    <= '0;
              state       <= IDLE;
              burst_cnt_q <= burst_cnt_q + 16'd1;
              prio        <= ~owner_q;
            end else begin
              word_cnt <= word_cnt + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    bus.fifo_wr_en = 1'b0;
    bus.fifo_din   = '0;
    bus.s0_ready   = 1'b0;
    bus.s1_ready   = 1'b0;
    if (!rst) begin
      case (state)
`ifdef FIFO_BURST_ARB_HDR_EN
        HDR: begin
          bus.fifo_wr_en = 1'b1;
          bus.fifo_din   = {8'hA5, 7'd0, owner_q, 16'(BURST_LEN)};
        end
`endif
        DATA: begin
          bus.s0_ready   = !owner_q && !bus.fifo_full;
          bus.s1_ready   = owner_q && !bus.fifo_full;
          bus.fifo_wr_en = accept;
          bus.fifo_din   = owner_q ? bus.s1_data : bus.s0_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.owner     = owner_q;
  assign bus.busy      = (state != IDLE) && !rst;
  assign bus.burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_burst_arb.sv
// Self-checking bench for fifo_burst_arb; expected FIFO writes are queued as stimulus
// is set up and popped as the DUT issues writes. Adapts to FIFO_BURST_ARB_HDR_EN.
module tb_fifo_burst_arb;
  localparam int DEPTH     = 256;
  localparam int BURST_LEN = 16;
`ifdef FIFO_BURST_ARB_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int THRESH = BURST_LEN + HDR_WORDS;
  localparam logic [31:0] S0_BASE = 32'hC0DE_0000;
  localparam logic [31:0] S1_BASE = 32'hBEEF_0000;

  logic clk;
  logic rst;
  fifo_burst_arb_if bus ();

  fifo_burst_arb #(.DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fails;
  int          wr_count;
  logic [31:0] exp_q[$];
  logic [15:0] seq0, seq1;
  logic [15:0] exp0, exp1;

  // Queue an optional header plus nwords data words of requester o.
  task automatic push_words(input logic o, input int nwords);
`ifdef FIFO_BURST_ARB_HDR_EN
    exp_q.push_back({8'hA5, 7'd0, o, 16'(BURST_LEN)});
`endif
    for (int i = 0; i < nwords; i++) begin
      if (o) begin
        exp_q.push_back(S1_BASE | 32'(exp1));
        exp1++;
      end else begin
        exp_q.push_back(S0_BASE | 32'(exp0));
        exp0++;
      end
    end
  endtask

  // One clock: sample at negedge, score any FIFO write, advance sources after the edge.
  task automatic tick();
    logic a0, a1;
    logic [31:0] e;
    @(negedge clk);
    a0 = bus.s0_valid && bus.s0_ready;
    a1 = bus.s1_valid && bus.s1_ready;
    n_checks++;
    if (bus.s0_ready && bus.s1_ready) begin
      n_fails++;
      $display("FAIL ready_exclusive: s0_ready=%b s1_ready=%b, required not both high", bus.s0_ready, bus.s1_ready);
    end
    if (bus.fifo_wr_en) begin
      wr_count++;
      n_checks++;
      if (bus.fifo_full) begin
        n_fails++;
        $display("FAIL write_while_full: fifo_wr_en=1 with fifo_full=1, required no write");
      end else if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_write: got %h, required no write", bus.fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (bus.fifo_din !== e) begin
          n_fails++;
          $display("FAIL fifo_din: got %h, required %h", bus.fifo_din, e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (a0) begin
      seq0++;
      bus.s0_data = S0_BASE | 32'(seq0);
    end
    if (a1) begin
      seq1++;
      bus.s1_data = S1_BASE | 32'(seq1);
    end
  endtask

  task automatic run_bursts(input logic [15:0] target, input int budget, output int used);
    used = 0;
    while (bus.burst_cnt !== target && used < budget) begin
      tick();
      used++;
    end
    n_checks++;
    if (bus.burst_cnt !== target) begin
      n_fails++;
      $display("FAIL burst_timeout: burst_cnt=%0d after %0d cycles, required %0d", bus.burst_cnt, used, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.fifo_dcnt = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.fifo_rdy = 1'b0;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks += 6;
    if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
      n_fails++; $display("FAIL reset_ready: got %b%b, required 00", bus.s0_ready, bus.s1_ready);
    end
    if (bus.fifo_wr_en !== 1'b0) begin n_fails++; $display("FAIL reset_wr_en: got %b, required 0", bus.fifo_wr_en); end
    if (bus.fifo_din !== 32'd0) begin n_fails++; $display("FAIL reset_din: got %h, required 0", bus.fifo_din); end
    if (bus.owner !== 1'b0) begin n_fails++; $display("FAIL reset_owner: got %b, required 0", bus.owner); end
    if (bus.burst_cnt !== 16'd0) begin n_fails++; $display("FAIL reset_burst_cnt: got %0d, required 0", bus.burst_cnt); end
    // FIFO not ready: both valid but nothing may be granted.
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL rdy_low_busy: got %b, required 0", bus.busy); end
    end
  endtask

  task automatic test_first_burst();
    int used, base;
    push_words(1'b0, BURST_LEN);
    bus.fifo_rdy = 1'b1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL first_pre_busy: got %b, required 0", bus.busy); end
    base = wr_count;
    tick();
    n_checks += 2;
    if (bus.busy !== 1'b1) begin n_fails++; $display("FAIL first_grant_busy: got %b, required 1", bus.busy); end
    if (bus.owner !== 1'b0) begin n_fails++; $display("FAIL first_owner: got %b, required 0", bus.owner); end
    tick();
    n_checks++;
    if (wr_count !== base + 1) begin n_fails++; $display("FAIL first_write_latency: writes=%0d, required %0d", wr_count - base, 1); end
    run_bursts(16'd1, 200, used);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    tick();
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL first_missing: %0d words outstanding, required 0", exp_q.size()); end
    if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL first_end_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int used;
    do_reset();
    for (int b = 0; b < 4; b++) push_words(1'(b % 2), BURST_LEN);
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    run_bursts(16'd4, 400, used);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    n_checks += 3;
    if (used !== 4 * (BURST_LEN + 1 + HDR_WORDS)) begin
      n_fails++; $display("FAIL rr_cycles: got %0d, required %0d", used, 4 * (BURST_LEN + 1 + HDR_WORDS));
    end
    if (bus.owner !== 1'b1) begin n_fails++; $display("FAIL rr_last_owner: got %b, required 1", bus.owner); end
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL rr_missing: %0d words outstanding, required 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_space_threshold();
    int used;
    do_reset();
    bus.fifo_dcnt = 8'(DEPTH - THRESH + 1);
    bus.s0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL space_short_busy: got %b, required 0", bus.busy); end
    end
    push_words(1'b0, BURST_LEN);
    bus.fifo_dcnt = 8'(DEPTH - THRESH);
    tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fails++; $display("FAIL space_exact_grant: got %b, required 1", bus.busy); end
    run_bursts(16'd1, 200, used);
    bus.s0_valid = 1'b0;
    bus.fifo_dcnt = 8'd0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL space_missing: %0d words outstanding, required 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_full_stall();
    int used, base;
    do_reset();
    push_words(1'b0, BURST_LEN);
    base = wr_count;
    bus.s0_valid = 1'b1;
    used = 0;
    while (wr_count < base + HDR_WORDS + 4 && used < 100) begin tick(); used++; end
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks += 3;
      if (bus.s0_ready !== 1'b0) begin n_fails++; $display("FAIL full_ready: got %b, required 0", bus.s0_ready); end
      if (bus.fifo_wr_en !== 1'b0) begin n_fails++; $display("FAIL full_wr_en: got %b, required 0", bus.fifo_wr_en); end
      if (bus.busy !== 1'b1) begin n_fails++; $display("FAIL full_busy: got %b, required 1", bus.busy); end
    end
    bus.fifo_full = 1'b0;
    run_bursts(16'd1, 200, used);
    bus.s0_valid = 1'b0;
    n_checks += 2;
    if (wr_count - base !== HDR_WORDS + BURST_LEN) begin
      n_fails++; $display("FAIL full_word_total: got %0d, required %0d", wr_count - base, HDR_WORDS + BURST_LEN);
    end
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL full_missing: %0d words outstanding, required 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int used, base;
    do_reset();
    push_words(1'b0, 5);
    base = wr_count;
    bus.s0_valid = 1'b1;
    used = 0;
    while (wr_count < base + HDR_WORDS + 5 && used < 100) begin tick(); used++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.s0_valid = 1'b0;
    n_checks += 5;
    if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
    if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
      n_fails++; $display("FAIL midrst_ready: got %b%b, required 00", bus.s0_ready, bus.s1_ready);
    end
    if (bus.burst_cnt !== 16'd0) begin n_fails++; $display("FAIL midrst_burst_cnt: got %0d, required 0", bus.burst_cnt); end
    if (wr_count - base !== HDR_WORDS + 5) begin
      n_fails++; $display("FAIL midrst_words: got %0d, required %0d", wr_count - base, HDR_WORDS + 5);
    end
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL midrst_missing: %0d words outstanding, required 0", exp_q.size()); end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_s1_alone();
    int used, base;
    do_reset();
    push_words(1'b1, BURST_LEN);
    bus.s1_valid = 1'b1;
    tick();
    n_checks += 2;
    if (bus.busy !== 1'b1) begin n_fails++; $display("FAIL s1_grant_busy: got %b, required 1", bus.busy); end
    if (bus.owner !== 1'b1) begin n_fails++; $display("FAIL s1_owner: got %b, required 1", bus.owner); end
    base = wr_count;
    tick();
    n_checks++;
    if (wr_count !== base + 1) begin n_fails++; $display("FAIL s1_first_write: writes=%0d, required 1", wr_count - base); end
    run_bursts(16'd1, 200, used);
    bus.s1_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL s1_missing: %0d words outstanding, required 0", exp_q.size()); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    wr_count = 0;
    seq0 = 16'd0;
    seq1 = 16'd0;
    exp0 = 16'd0;
    exp1 = 16'd0;
    rst = 1'b1;
    bus.fifo_rdy  = 1'b0;
    bus.fifo_full = 1'b0;
    bus.fifo_dcnt = 8'd0;
    bus.s0_valid  = 1'b0;
    bus.s1_valid  = 1'b0;
    bus.s0_data   = S0_BASE;
    bus.s1_data   = S1_BASE;

    test_reset();
    test_first_burst();
    test_round_robin();
    test_space_threshold();
    test_full_stall();
    test_reset_mid_burst();
    test_s1_alone();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fifo_burst_arb.md
FIFO_BURST_ARB -- requirements
Module: fifo_burst_arb

Interface
REQ-001 Parameter: DEPTH, default 256, FIFO capacity in 32-bit words.
REQ-002 Parameter: BURST_LEN, default 16, data words per burst; legal range 1..64.
REQ-003 Port: clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: fifo_rdy  input  1  FIFO out of reset; no burst starts while low.
REQ-006 Port: fifo_full  input  1  FIFO full flag.
REQ-007 Port: fifo_dcnt  input  8  FIFO data count.
REQ-008 Port: fifo_wr_en  output  1  FIFO write strobe.
REQ-009 Port: fifo_din  output  32  FIFO write data.
REQ-010 Port: s0_valid / s1_valid  input  1 each  requester word available.
REQ-011 Port: s0_data / s1_data  input  32 each  requester word.
REQ-012 Port: s0_ready / s1_ready  output  1 each  requester word accepted when valid and ready are both high.
REQ-013 Port: owner  output  1  index of the requester holding or last holding the grant.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: burst_cnt  output  16  completed bursts, wraps 0xFFFF->0x0000.

Function
REQ-016 FSM states: IDLE, HDR, DATA; IDLE->HDR on grant, HDR->DATA after one cycle, DATA->IDLE after the BURST_LEN-th accepted word.
REQ-017 Free space: 0 when fifo_full, else DEPTH-fifo_dcnt (computed at 9 bits).
REQ-018 Grant condition in IDLE: fifo_rdy high, at least one sN_valid high, free >= BURST_LEN+1 (header included).
REQ-019 Arbitration: round-robin; when both valid, the requester other than the last completed owner wins; after reset s0 wins.
REQ-020 Grant is registered: owner updates and state leaves IDLE on the edge following the qualifying cycle.
REQ-021 HDR: fifo_wr_en=1 for exactly one cycle, fifo_din={8'hA5, 7'd0, owner, 16'(BURST_LEN)}.
REQ-022 DATA: sN_ready = (owner==N) && !fifo_full; the non-owner's ready is 0.
REQ-023 DATA: fifo_wr_en = owner valid && owner ready; fifo_din = owner data, combinational pass-through, zero added latency.
REQ-024 Word counter increments per accepted word; a burst never terminates early; owner stalls (valid low) hold the FSM in DATA indefinitely.
REQ-025 fifo_full during DATA deasserts ready and stalls; no write issued while fifo_full high.
REQ-026 IDLE: fifo_wr_en=0, fifo_din=0, both readies 0.
REQ-027 burst_cnt increments on the DATA->IDLE edge; last-owner priority pointer updates on the same edge.
REQ-028 Minimum latency: qualifying cycle t -> header written t+1 -> first data word accepted t+2; back-to-back bursts separated by one IDLE cycle.

Reset
REQ-029 rst high on a clock edge: state=IDLE, word counter=0, owner=0, priority pointer=s0, burst_cnt=0.
REQ-030 Outputs during/after reset: fifo_wr_en=0, fifo_din=0, s0_ready=s1_ready=0, busy=0.
REQ-031 Reset mid-burst abandons the burst; words already written stay in the FIFO; no further words of that burst are written.

Configuration
REQ-032 Macro FIFO_BURST_ARB_HDR_EN defined: HDR state present, header written per REQ-021, space threshold BURST_LEN+1.
REQ-033 Macro undefined: no HDR state, IDLE->DATA directly, space threshold BURST_LEN, first data accept at t+1; all other behaviour identical.

Verification
REQ-034 Reset, fifo_rdy=0, both valid -> no grant, fifo_wr_en stays 0; fifo_rdy=1 -> header 0xA5000010, then 16 s0 words, burst_cnt=1.
REQ-035 Both requesters continuously valid, 4 bursts -> owners 0,1,0,1; headers 0xA5000010, 0xA5010010 alternate; burst_cnt=4.
REQ-036 fifo_dcnt=240 (free 16 < 17) with s0 valid -> stays IDLE; dcnt drops to 239 -> grant next edge.
REQ-037 fifo_full pulsed 3 cycles mid-DATA -> s0_ready low, no writes those cycles, burst still totals exactly 16 data words.
REQ-038 rst asserted after 5 data words -> next edge: busy=0, readies 0, burst_cnt=0, FIFO holds header+5 words only.
REQ-039 Macro undefined, s1 valid alone -> first s1 word written one cycle after grant, no 0xA5 header word in FIFO.
